// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge
//   Load/store unit sitting between a single-cycle RV32I core's data port and a
//   word-wide request/grant/rvalid bus. Turns byte-addressed accesses into
//   word-aligned transactions with byte strobes, stalls the core across bus
//   wait states, extends load data and flags misaligned, illegal or timed-out
//   accesses.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req_valid/we/addr/wdata/funct3   core access request
//   stall              hold the core this cycle
//   rsp_rdata          extended load data, valid when stall=0 after a load
//   err                one-cycle pulse in DONE for a failed access
//   bus_req/we/addr/wstrb/wdata      bus request side, bus_req held until bus_gnt
//   bus_gnt, bus_rvalid, bus_rdata   bus grant and response
module lsu_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        stall,
  output logic [31:0] rsp_rdata,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, cnt_inc;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        bad_access;
  logic [3:0]  lane_strb;
  logic [31:0] lane_data;
  logic [31:0] rd_shifted;
  logic [31:0] load_ext;

  // Illegal funct3 (011, 110, 111) or a halfword/word not naturally aligned.
  always_comb begin
    bad_access = 1'b0;
    if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11) begin
      bad_access = 1'b1;
    end else if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
      bad_access = 1'b1;
    end else if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) begin
      bad_access = 1'b1;
    end
  end

  // Store lane placement from the access size and low address bits.
  always_comb begin
    lane_strb = 4'b1111;
    lane_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        lane_strb = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_strb = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_strb = 4'b1111;
        lane_data = req_wdata;
      end
    endcase
  end

  // Word addresses are aligned, so the shift is zero for LW.
  assign rd_shifted = bus_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = rd_shifted;
    case (f3_q[1:0])
      2'b00:   load_ext = {{24{~f3_q[2] & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_ext = {{16{~f3_q[2] & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_ext = rd_shifted;
    endcase
  end

  assign cnt_inc = cnt_q + 32'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (bad_access) begin
            state_d = StDone;
            err_d   = 1'b1;
            if (!req_we) rdata_d = '0;
          end else begin
            state_d = StReq;
            cnt_d   = '0;
            we_d    = req_we;
            addr_d  = req_addr;
            f3_d    = req_funct3;
            wstrb_d = req_we ? lane_strb : 4'b0000;
            wdata_d = req_we ? lane_data : '0;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_inc;
        // A grant on the last allowed cycle still times out: no cycle is left for rvalid.
        if (cnt_inc >= TIMEOUT_CYCLES) begin
          state_d = StDone;
          err_d   = 1'b1;
          if (!we_q) rdata_d = '0;
        end else if (bus_gnt) begin
          state_d = StResp;
        end
      end
      StResp: begin
        cnt_d = cnt_inc;
        // A response on the last allowed cycle wins over the timeout.
        if (bus_rvalid) begin
          state_d = StDone;
          if (!we_q) rdata_d = load_ext;
        end else if (cnt_inc >= TIMEOUT_CYCLES) begin
          state_d = StDone;
          err_d   = 1'b1;
          if (!we_q) rdata_d = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      f3_q    <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign stall     = req_valid & (state_q != StDone) & ~rst;
  assign bus_req   = (state_q == StReq);
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;
  assign rsp_rdata = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Randomized bench for lsu_bus_bridge with a transaction-level reference model.
module tb_lsu_bus_bridge;

  localparam int unsigned Tmo = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        stall;
  logic [31:0] rsp_rdata;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rsp_model = '0;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_funct3(req_funct3),
    .stall     (stall),
    .rsp_rdata (rsp_rdata),
    .err       (err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_gnt   (bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    logic [1:0] s;
    s = f3[1:0];
    return 1 << s;
  endfunction

  function automatic bit is_legal(input logic [2:0] f3, input logic [31:0] a);
    logic [1:0] lo;
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b0;
    lo = a[1:0];
    return (int'(lo) % acc_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
    int mask;
    logic [1:0] lo;
    lo = a[1:0];
    mask = (1 << acc_size(f3)) - 1;
    return 4'((mask << lo) & 15);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (acc_size(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [31:0] sh, v;
    logic [1:0] lo;
    lo = a[1:0];
    sh = d >> (8 * int'(lo));
    case (acc_size(f3))
      1: begin
        v = sh & 32'hFF;
        if (f3 < 3'd4 && v >= 32'd128) v = v - 32'd256;
      end
      2: begin
        v = sh & 32'hFFFF;
        if (f3 < 3'd4 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  // One access; responder grants after gd waiting REQ cycles, answers rd cycles after grant.
  // Called and returns at negedge+1 with the DUT idle.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] f3, input logic [31:0] rdata,
                            input int gd, input int rd);
    int  total, exp_stall, exp_req, stall_cyc, req_cyc, post;
    bit  legal, tmo, granted, seen_err, fields_done;
    legal     = is_legal(f3, addr);
    total     = gd + 1 + rd;
    tmo       = legal && (total > int'(Tmo));
    exp_stall = legal ? 1 + (tmo ? int'(Tmo) : total) : 1;
    exp_req   = legal ? ((gd + 1 > int'(Tmo)) ? int'(Tmo) : gd + 1) : 0;

    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    #1;
    stall_cyc = 0; req_cyc = 0; post = 0;
    granted = 1'b0; seen_err = 1'b0; fields_done = 1'b0;
    while (stall === 1'b1 && stall_cyc < 64) begin
      stall_cyc++;
      if (err !== 1'b0) seen_err = 1'b1;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
      if (granted) begin
        check("req_drop", {31'd0, bus_req}, 32'd0);
        post++;
        if (post == rd) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rdata;
        end
      end else if (bus_req === 1'b1) begin
        req_cyc++;
        if (!fields_done) begin
          fields_done = 1'b1;
          check("bus_addr", bus_addr, addr & ~32'd3);
          check("bus_we", {31'd0, bus_we}, {31'd0, we});
          check("bus_wstrb", {28'd0, bus_wstrb}, we ? {28'd0, exp_strb(f3, addr)} : 32'd0);
          if (we) check("bus_wdata", bus_wdata, exp_wdata(f3, wdata));
        end
        if (req_cyc == gd + 1) begin
          bus_gnt = 1'b1;
          granted = 1'b1;
        end
      end
      @(negedge clk);
      #1;
    end
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;

    if (!legal || tmo) begin
      if (!we) rsp_model = '0;
    end else if (!we) begin
      rsp_model = exp_load(f3, addr, rdata);
    end
    check("stall_cycles", stall_cyc, exp_stall);
    check("req_cycles", req_cyc, exp_req);
    check("err_in_stall", {31'd0, seen_err}, 32'd0);
    check("err_done", {31'd0, err}, {31'd0, (!legal || tmo)});
    check("rsp_rdata", rsp_rdata, rsp_model);

    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("err_pulse", {31'd0, err}, 32'd0);
  endtask

  // Idle cycle with stray grant/response that must be ignored.
  task automatic stray_cycle();
    bus_gnt    = 1'($urandom_range(0, 1));
    bus_rvalid = 1'($urandom_range(0, 1));
    bus_rdata  = $urandom;
    @(negedge clk);
    #1;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    check("stray_req", {31'd0, bus_req}, 32'd0);
    check("stray_rsp", rsp_rdata, rsp_model);
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    // Reset state, stall masked by rst.
    req_valid = 1'b1;
    #3;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, bus_req}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_rsp", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Directed cases.
    run_access(1'b0, 32'h100, 32'h0, 3'b010, 32'h8000_00F0, 0, 1);
    run_access(1'b1, 32'h203, 32'h1234_56AB, 3'b000, 32'h0, 0, 1);
    run_access(1'b1, 32'h202, 32'h0000_BEEF, 3'b001, 32'h0, 1, 2);
    run_access(1'b0, 32'h11, 32'h0, 3'b000, 32'h0000_8000, 0, 1);
    run_access(1'b0, 32'h11, 32'h0, 3'b100, 32'h0000_8000, 0, 1);
    run_access(1'b0, 32'h12, 32'h0, 3'b001, 32'h8001_0000, 0, 1);
    run_access(1'b0, 32'h12, 32'h0, 3'b101, 32'h8001_0000, 0, 1);
    run_access(1'b0, 32'h102, 32'h0, 3'b010, 32'h0, 0, 1);
    run_access(1'b1, 32'h101, 32'h5555, 3'b001, 32'h0, 0, 1);
    run_access(1'b0, 32'h40, 32'h0, 3'b011, 32'h0, 0, 1);
    run_access(1'b0, 32'h44, 32'h0, 3'b010, 32'hCAFE_F00D, 5, 3);
    run_access(1'b0, 32'h48, 32'h0, 3'b010, 32'h1111_2222, 1000, 1);
    stray_cycle();
    stray_cycle();
    run_access(1'b1, 32'h500, 32'hA5A5_5A5A, 3'b010, 32'h0, 0, 1);
    run_access(1'b1, 32'h504, 32'h0F0F_F0F0, 3'b010, 32'h0, 0, 1);

    // Reset while waiting for the response.
    run_access(1'b0, 32'h60, 32'h0, 3'b010, 32'h1357_9BDF, 0, 1);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h300;
    req_funct3 = 3'b010;
    @(negedge clk);
    #1;
    bus_gnt = 1'b1;
    @(negedge clk);
    #1;
    bus_gnt = 1'b0;
    check("resp_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_req", {31'd0, bus_req}, 32'd0);
    check("midrst_addr", bus_addr, 32'd0);
    check("midrst_we", {31'd0, bus_we}, 32'd0);
    check("midrst_rsp", rsp_rdata, 32'd0);
    rsp_model = '0;
    @(negedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    run_access(1'b0, 32'h300, 32'h0, 3'b010, 32'h2468_ACE0, 0, 1);

    // Randomized accesses.
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (we && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
      run_access(we, $urandom, $urandom, f3, $urandom,
                 int'($urandom_range(0, 10)), int'($urandom_range(1, 4)));
      if ($urandom_range(0, 3) == 0) stray_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
